// File: rtl/dbus_dual_issue_pkg.sv
// Shared data-bus types for the memory stage: request/response payloads and the
// dual-issue serializer state encoding.
package dbus_dual_issue_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [STRB_W-1:0] strobe_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        DI_IDLE,
        DI_REQ1,
        DI_WAIT1,
        DI_REQ0,
        DI_WAIT0,
        DI_DONE,
        DI_DRAIN
    } dual_issue_state_t;

    // Reads and cache ops carry no byte strobes; only those return data.
    function automatic logic is_read(input dbus_req_t r);
        return r.strobe == '0;
    endfunction

endpackage

// File: rtl/dbus_dual_issue.sv
// Serializes the two memory-stage data-bus requests (slot 1 first) onto one bus port
// and returns per-slot read data; stalls the stage until every valid slot completes.
module dbus_dual_issue
    import dbus_dual_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  dbus_req_t [1:0]      dreq_i,
    input  logic                 kill0_i,
    input  logic                 flush_i,
    input  logic                 advance_i,
    output dbus_req_t            dreq_o,
    input  dbus_resp_t           dresp_i,
    output word_t [1:0]          rdata_o,
    output logic                 stall_o
);

    dual_issue_state_t state_q, state_d;
    word_t [1:0]       rdata_q, rdata_d;

    logic              need1, need0;
    logic              issue;
    logic              slot;
    dual_issue_state_t after_slot;

    assign need1 = dreq_i[1].valid;
    assign need0 = dreq_i[0].valid & ~kill0_i;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        dreq_o     = '0;
        stall_o    = 1'b0;
        issue      = 1'b0;
        slot       = 1'b0;

        case (state_q)
            DI_IDLE: begin
                stall_o = need1 | need0;
                if (need1) begin
                    issue   = 1'b1;
                    slot    = 1'b1;
                    state_d = DI_REQ1;
                end else if (need0) begin
                    issue   = 1'b1;
                    state_d = DI_REQ0;
                end
            end
            DI_REQ1: begin
                issue   = 1'b1;
                slot    = 1'b1;
                stall_o = 1'b1;
            end
            DI_REQ0: begin
                issue   = 1'b1;
                stall_o = 1'b1;
            end
            DI_WAIT1, DI_WAIT0: begin
                stall_o = 1'b1;
                slot    = (state_q == DI_WAIT1);
            end
            DI_DONE: begin
                if (flush_i || advance_i) begin
                    state_d = DI_IDLE;
                end
            end
            DI_DRAIN: begin
                stall_o = 1'b1;
                if (dresp_i.data_ok) begin
                    state_d = DI_IDLE;
                end
            end
            default: state_d = DI_IDLE;
        endcase

        // need0 is re-sampled after slot 1 so a late kill0_i still suppresses slot 0
        after_slot = (slot && need0) ? DI_REQ0 : DI_DONE;

        if (issue) begin
            dreq_o = dreq_i[slot];
            if (dresp_i.addr_ok && dresp_i.data_ok) begin
                if (flush_i) begin
                    state_d = DI_IDLE;
                end else begin
                    if (is_read(dreq_i[slot])) begin
                        rdata_d[slot] = dresp_i.data;
                    end
                    state_d = after_slot;
                    // Single request finishing in IDLE: stage moves on this cycle
                    if (state_q == DI_IDLE && after_slot == DI_DONE) begin
                        stall_o = 1'b0;
                        if (advance_i) begin
                            state_d = DI_IDLE;
                        end
                    end
                end
            end else if (dresp_i.addr_ok) begin
                if (flush_i) begin
                    state_d = DI_DRAIN;
                end else begin
                    state_d = slot ? DI_WAIT1 : DI_WAIT0;
                end
            end else if (flush_i) begin
                state_d = DI_IDLE;
            end
        end else if (state_q == DI_WAIT1 || state_q == DI_WAIT0) begin
            if (dresp_i.data_ok) begin
                if (flush_i) begin
                    state_d = DI_IDLE;
                end else begin
                    if (is_read(dreq_i[slot])) begin
                        rdata_d[slot] = dresp_i.data;
                    end
                    state_d = after_slot;
                end
            end else if (flush_i) begin
                state_d = DI_DRAIN;
            end
        end

        if (reset) begin
            dreq_o  = '0;
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DI_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dbus_dual_issue.sv
// Directed bench for dbus_dual_issue with a latency-programmable bus responder.
module tb_dbus_dual_issue;
    import dbus_dual_issue_pkg::*;

    logic        clk;
    logic        reset;
    dbus_req_t [1:0] dreq_i;
    logic        kill0_i;
    logic        flush_i;
    logic        advance_i;
    dbus_req_t   dreq_o;
    dbus_resp_t  dresp_i;
    word_t [1:0] rdata_o;
    logic        stall_o;

    int n_total = 0;
    int n_bad   = 0;

    // Bus responder knobs and state
    int unsigned addr_lat, data_lat;
    int unsigned wait_cnt, data_cnt;
    logic        pending;
    addr_t       lat_addr, cur_addr, s1_addr;
    word_t       d1, d0;

    int          t2_sel   [9] = '{1, 1, 0, 0, 2, 2, 0, 0, 0};
    logic        t2_stall [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dbus_req_t   exp_req;

    dbus_dual_issue dut (
        .clk       (clk),
        .reset     (reset),
        .dreq_i    (dreq_i),
        .kill0_i   (kill0_i),
        .flush_i   (flush_i),
        .advance_i (advance_i),
        .dreq_o    (dreq_o),
        .dresp_i   (dresp_i),
        .rdata_o   (rdata_o),
        .stall_o   (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dresp_i         = '0;
        cur_addr        = pending ? lat_addr : dreq_o.addr;
        dresp_i.addr_ok = dreq_o.valid && !pending && (wait_cnt == addr_lat);
        dresp_i.data_ok = (dresp_i.addr_ok && data_lat == 0) || (pending && data_cnt == data_lat);
        dresp_i.data    = (cur_addr == s1_addr) ? d1 : d0;
    end

    always @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            wait_cnt <= 0;
            data_cnt <= 0;
            lat_addr <= '0;
        end else begin
            if (dresp_i.addr_ok) begin
                wait_cnt <= 0;
                if (!dresp_i.data_ok) begin
                    pending  <= 1'b1;
                    data_cnt <= 1;
                    lat_addr <= dreq_o.addr;
                end
            end else if (dreq_o.valid && !pending) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
            end
            if (pending) begin
                if (dresp_i.data_ok) pending <= 1'b0;
                else data_cnt <= data_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic dbus_req_t mk(input logic v, input addr_t a, input strobe_t s, input word_t d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.strobe = s;
        r.data   = d;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; dreq_i = '0; kill0_i = 1'b0; flush_i = 1'b0; advance_i = 1'b0;
        addr_lat = 0; data_lat = 0; s1_addr = '0; d1 = '0; d0 = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_state", 96'(dut.state_q), 96'(DI_IDLE));
        chk("rst_dreq",  96'(dreq_o), 96'(0));
        chk("rst_stall", 96'(stall_o), 96'(0));
        chk("rst_rdata", 96'(rdata_o), 96'(0));

        // 1: two loads, immediate completion
        cyc();
        reset = 1'b0; s1_addr = 32'h8000_0010; d1 = 32'h11; d0 = 32'h22;
        dreq_i[1] = mk(1'b1, 32'h8000_0010, 4'h0, 32'h0);
        dreq_i[0] = mk(1'b1, 32'h8000_0014, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1_c0_req",   96'(dreq_o), 96'(dreq_i[1]));
        chk("t1_c0_stall", 96'(stall_o), 96'(1));
        cyc();
        @(negedge clk);
        chk("t1_c1_req",   96'(dreq_o), 96'(dreq_i[0]));
        chk("t1_c1_stall", 96'(stall_o), 96'(1));
        cyc();
        advance_i = 1'b1; dreq_i = '0;
        @(negedge clk);
        chk("t1_done_state", 96'(dut.state_q), 96'(DI_DONE));
        chk("t1_done_stall", 96'(stall_o), 96'(0));
        chk("t1_rdata1",     96'(rdata_o[1]), 96'(32'h11));
        chk("t1_rdata0",     96'(rdata_o[0]), 96'(32'h22));
        cyc();
        advance_i = 1'b0;
        @(negedge clk);
        chk("t1_idle_state", 96'(dut.state_q), 96'(DI_IDLE));

        // 2: store s1 + load s0, addr_ok at +1, data_ok at +3
        cyc();
        s1_addr = 32'h8000_0020; d1 = 32'hdead_0001; d0 = 32'h33;
        addr_lat = 1; data_lat = 2;
        dreq_i[1] = mk(1'b1, 32'h8000_0020, 4'b0011, 32'hdead_beef);
        dreq_i[0] = mk(1'b1, 32'h8000_0024, 4'h0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            if (i == 8) begin
                advance_i = 1'b1;
                dreq_i = '0;
            end
            @(negedge clk);
            if (t2_sel[i] == 1) exp_req = mk(1'b1, 32'h8000_0020, 4'b0011, 32'hdead_beef);
            else if (t2_sel[i] == 2) exp_req = mk(1'b1, 32'h8000_0024, 4'h0, 32'h0);
            else exp_req = '0;
            chk($sformatf("t2_req_c%0d", i),   96'(dreq_o), 96'(exp_req));
            chk($sformatf("t2_stall_c%0d", i), 96'(stall_o), 96'(t2_stall[i]));
        end
        chk("t2_done_state", 96'(dut.state_q), 96'(DI_DONE));
        chk("t2_rdata0",     96'(rdata_o[0]), 96'(32'h33));
        cyc();
        advance_i = 1'b0;
        @(negedge clk);
        chk("t2_idle_state", 96'(dut.state_q), 96'(DI_IDLE));

        // 3: kill0_i rises while slot 1 waits for data
        cyc();
        s1_addr = 32'h8000_0030; d1 = 32'h44; d0 = 32'h55;
        addr_lat = 0; data_lat = 2;
        dreq_i[1] = mk(1'b1, 32'h8000_0030, 4'h0, 32'h0);
        dreq_i[0] = mk(1'b1, 32'h8000_0034, 4'h0, 32'h0);
        @(negedge clk);
        chk("t3_c0_req", 96'(dreq_o), 96'(dreq_i[1]));
        cyc();
        kill0_i = 1'b1;
        @(negedge clk);
        chk("t3_c1_valid", 96'(dreq_o.valid), 96'(0));
        chk("t3_c1_stall", 96'(stall_o), 96'(1));
        cyc();
        @(negedge clk);
        chk("t3_c2_valid", 96'(dreq_o.valid), 96'(0));
        chk("t3_c2_stall", 96'(stall_o), 96'(1));
        cyc();
        advance_i = 1'b1;
        @(negedge clk);
        chk("t3_done_state", 96'(dut.state_q), 96'(DI_DONE));
        chk("t3_done_valid", 96'(dreq_o.valid), 96'(0));
        chk("t3_done_stall", 96'(stall_o), 96'(0));
        chk("t3_rdata1",     96'(rdata_o[1]), 96'(32'h44));
        cyc();
        advance_i = 1'b0; kill0_i = 1'b0; dreq_i = '0;
        @(negedge clk);
        chk("t3_idle_state", 96'(dut.state_q), 96'(DI_IDLE));

        // 4: flush while waiting on slot 1, data_ok two cycles later
        cyc();
        s1_addr = 32'h8000_0040; d1 = 32'h66; d0 = 32'h77;
        addr_lat = 0; data_lat = 3;
        dreq_i[1] = mk(1'b1, 32'h8000_0040, 4'h0, 32'h0);
        dreq_i[0] = mk(1'b1, 32'h8000_0044, 4'h0, 32'h0);
        @(negedge clk);
        chk("t4_c0_req", 96'(dreq_o), 96'(dreq_i[1]));
        cyc();
        flush_i = 1'b1;
        @(negedge clk);
        chk("t4_c1_stall", 96'(stall_o), 96'(1));
        cyc();
        flush_i = 1'b0; dreq_i = '0;
        @(negedge clk);
        chk("t4_drain_state", 96'(dut.state_q), 96'(DI_DRAIN));
        chk("t4_drain_stall", 96'(stall_o), 96'(1));
        cyc();
        @(negedge clk);
        chk("t4_drain2_stall", 96'(stall_o), 96'(1));
        chk("t4_drain2_valid", 96'(dreq_o.valid), 96'(0));
        cyc();
        @(negedge clk);
        chk("t4_idle_state", 96'(dut.state_q), 96'(DI_IDLE));
        chk("t4_idle_stall", 96'(stall_o), 96'(0));
        chk("t4_idle_valid", 96'(dreq_o.valid), 96'(0));
        chk("t4_rdata1",     96'(rdata_o[1]), 96'(32'h44));
        chk("t4_rdata0",     96'(rdata_o[0]), 96'(32'h33));

        // 5: lone slot 1 completes in IDLE, then DONE held without advance
        cyc();
        s1_addr = 32'h8000_0050; d1 = 32'h88; d0 = 32'h0;
        addr_lat = 0; data_lat = 0;
        dreq_i[1] = mk(1'b1, 32'h8000_0050, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5_c0_req",   96'(dreq_o), 96'(dreq_i[1]));
        chk("t5_c0_stall", 96'(stall_o), 96'(0));
        for (int i = 1; i <= 3; i++) begin
            cyc();
            if (i == 3) begin
                advance_i = 1'b1;
                dreq_i = '0;
            end
            @(negedge clk);
            chk($sformatf("t5_state_c%0d", i), 96'(dut.state_q), 96'(DI_DONE));
            chk($sformatf("t5_valid_c%0d", i), 96'(dreq_o.valid), 96'(0));
            chk($sformatf("t5_stall_c%0d", i), 96'(stall_o), 96'(0));
            chk($sformatf("t5_rdata_c%0d", i), 96'(rdata_o[1]), 96'(32'h88));
        end
        cyc();
        advance_i = 1'b0;
        @(negedge clk);
        chk("t5_idle_state", 96'(dut.state_q), 96'(DI_IDLE));

        // 6: reset while slot 0 is requesting
        cyc();
        s1_addr = 32'h8000_0060; d1 = 32'h99; d0 = 32'haa;
        addr_lat = 2; data_lat = 0;
        dreq_i[1] = mk(1'b1, 32'h8000_0060, 4'h0, 32'h0);
        dreq_i[0] = mk(1'b1, 32'h8000_0064, 4'h0, 32'h0);
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("t6_req0_state", 96'(dut.state_q), 96'(DI_REQ0));
        chk("t6_req0_req",   96'(dreq_o), 96'(dreq_i[0]));
        chk("t6_rdata1",     96'(rdata_o[1]), 96'(32'h99));
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("t6_rst_state", 96'(dut.state_q), 96'(DI_IDLE));
        chk("t6_rst_valid", 96'(dreq_o.valid), 96'(0));
        chk("t6_rst_stall", 96'(stall_o), 96'(0));
        chk("t6_rst_rdata", 96'(rdata_o), 96'(0));
        cyc();
        reset = 1'b0; dreq_i = '0;
        @(negedge clk);
        chk("t6_post_stall", 96'(stall_o), 96'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
